leading_zero_cnt: RTL and testbench
===================================

LEADING_ZERO_CNT -- requirements
Module: leading_zero_cnt

Interface
REQ-001 SHALL have parameter WI_SZ, default 32: input width; legal values 8, 16, 32, 64 only.
REQ-002 SHALL have parameter WO_SZ, default $clog2(WI_SZ)+1: count width; must be at least $clog2(WI_SZ)+1.
REQ-003 SHALL have port clk, input, 1: the single clock; all sequential logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in, input, WI_SZ: operand; bit WI_SZ-1 is the MSB.
REQ-006 SHALL have port out, output, WO_SZ: combinational leading-zero count of in.
REQ-007 SHALL have port out_q, output, WO_SZ: out registered on clk.
REQ-008 SHALL have port zero, output, 1: combinational flag, high when in == 0.

Function
REQ-009 SHALL drive out with the number of consecutive 0 bits counting down from bit WI_SZ-1 to the first 1 bit.
REQ-010 SHALL drive out = WI_SZ when in == 0; this is the only case where out[WO_SZ-1] is set when WO_SZ = $clog2(WI_SZ)+1.
REQ-011 SHALL drive out = 0 whenever in[WI_SZ-1] = 1, regardless of the lower bits.
REQ-012 SHALL make out purely combinational, with zero latency; out settles in the same delta/time step as in, and with no dependence on clk or rst_n.
REQ-013 SHALL zero-extend the count into WO_SZ bits when WO_SZ exceeds the minimum.
REQ-014 SHALL load out_q with out on every rising clk edge; no enable; 1-cycle latency.
REQ-015 SHALL drive zero = 1 exactly when in == 0, consistent with out == WI_SZ.
REQ-016 SHALL contain no X-propagation on out when in is fully 0/1 driven.
REQ-017 SHALL reject unsupported WI_SZ at elaboration with a fatal error.

Reset
REQ-018 SHALL clear out_q to 0 immediately on rst_n low, independent of clk.
REQ-019 SHALL hold out_q at 0 while rst_n is low and resume loading on the first rising clk after release.
REQ-020 SHALL leave out and zero unaffected by rst_n; they track in during reset.

Structure
REQ-021 SHALL compute the count as a log2(WI_SZ)-level binary tree rather than a priority chain.
REQ-022 SHALL use leaves that encode 2-bit groups as {all-zero, count}.
REQ-023 SHALL merge sibling nodes as follows: if the left (upper) node is all-zero, result = {1, right count}; otherwise result = {0, left count}; all-zero = both all-zero.
REQ-024 SHALL implement the merge node as one sub-module, lzc_merge, parameterised by level width, instantiated through generate loops.
REQ-025 SHALL place the supported-width list and the count-width function (clog2+1) in a shared package, lzc_pkg.

Verification
REQ-026 SHALL verify: WI_SZ=32, in=32'h0000_0000 -> out=32, zero=1.
REQ-027 SHALL verify: in=32'h8000_0000 and in=32'hFFFF_FFFF -> out=0, zero=0.
REQ-028 SHALL verify: single 1 walked from bit 31 down to bit 0 -> out=31-k for bit k, for example bit 0 gives out=31.
REQ-029 SHALL verify: thermometer vectors (1 at bit k, all lower bits 1) -> same counts as single-1 vectors, so lower bits do not affect the result.
REQ-030 SHALL verify: in=32'h0001_0000 applied before a rising edge -> out_q=15 after that edge; rst_n pulsed low mid-cycle -> out_q=0 immediately while out stays 15.
REQ-031 SHALL verify: repeat the zero, single-1 and thermometer sweeps (2*WI_SZ+1 vectors) for WI_SZ = 8, 16 and 64, e.g. WI_SZ=64 with in=0 -> out=64.

Source files
------------

// File: rtl/lzc_pkg.sv
// Shared widths and helpers for the leading-zero counter.
// Lists the operand widths the tree supports and sizes the count.
package lzc_pkg;

  localparam int LZC_N_W = 4;
  localparam int LZC_W_LIST [LZC_N_W] = '{8, 16, 32, 64};

  function automatic bit lzc_width_ok(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < LZC_N_W; i++) begin
      if (LZC_W_LIST[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic int lzc_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/lzc_merge.sv
// One node of the leading-zero tree: joins an upper and lower half.
// An all-zero upper half defers to the lower half's count with the MSB set.
module lzc_merge
  import lzc_pkg::*;
#(
  parameter int CW = 1
) (
  input  logic          lz,
  input  logic [CW-1:0] lc,
  input  logic          rz,
  input  logic [CW-1:0] rc,
  output logic          z,
  output logic [CW:0]   c
);

  assign z = lz & rz;
  assign c = lz ? {1'b1, rc} : {1'b0, lc};

endmodule

// File: rtl/leading_zero_cnt.sv
// Leading-zero counter built as a binary tree of 2-bit leaves.
// Provides a combinational count, a zero flag and a registered count.
module leading_zero_cnt
  import lzc_pkg::*;
#(
  parameter int WI_SZ = 32,
  parameter int WO_SZ = lzc_cnt_w(WI_SZ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WI_SZ-1:0] in,
  output logic [WO_SZ-1:0] out,
  output logic [WO_SZ-1:0] out_q,
  output logic             zero
);

  localparam int LV = $clog2(WI_SZ);

  if (!lzc_width_ok(WI_SZ)) begin : g_bad_wi
    $fatal(1, "leading_zero_cnt: unsupported WI_SZ %0d", WI_SZ);
  end

  if (WO_SZ < lzc_cnt_w(WI_SZ)) begin : g_bad_wo
    $fatal(1, "leading_zero_cnt: WO_SZ %0d too small", WO_SZ);
  end

  // Node 0 of every level sits at the MSB end of the operand.
  genvar lv, n;
  for (lv = 0; lv < LV; lv++) begin : g_lvl
    localparam int NN = WI_SZ >> (lv + 1);
    logic [NN-1:0]      z;
    logic [NN-1:0][lv:0] c;

    if (lv == 0) begin : g_leaf
      for (n = 0; n < NN; n++) begin : g_n
        logic [1:0] p;
        assign p    = in[WI_SZ-1-2*n -: 2];
        assign z[n] = ~|p;
        assign c[n] = ~p[1];
      end
    end else begin : g_node
      for (n = 0; n < NN; n++) begin : g_n
        lzc_merge #(
          .CW(lv)
        ) u_merge (
          .lz(g_lvl[lv-1].z[2*n]),
          .lc(g_lvl[lv-1].c[2*n]),
          .rz(g_lvl[lv-1].z[2*n+1]),
          .rc(g_lvl[lv-1].c[2*n+1]),
          .z (z[n]),
          .c (c[n])
        );
      end
    end
  end

  logic          root_z;
  logic [LV-1:0] root_c;

  assign root_z = g_lvl[LV-1].z[0];
  assign root_c = g_lvl[LV-1].c[0];

  // All-zero input leaves the tree count saturated; replace it with WI_SZ.
  always_comb begin
    out           = '0;
    out[LV]       = root_z;
    out[LV-1:0]   = root_c & {LV{~root_z}};
  end

  assign zero = root_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out;
  end

endmodule

// File: tb/tb_leading_zero_cnt.sv
// Scoreboard bench for leading_zero_cnt at widths 8/16/32/64
// plus a 32-bit instance with a widened count.
module tb_leading_zero_cnt;

  logic clk;
  logic rst_n;

  logic [7:0]  in8;
  logic [15:0] in16;
  logic [31:0] in32;
  logic [63:0] in64;

  logic [3:0] out8,  q8;
  logic [4:0] out16, q16;
  logic [5:0] out32, q32;
  logic [6:0] out64, q64;
  logic [7:0] out32w, q32w;
  logic z8, z16, z32, z64, z32w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int e8;
    int e16;
    int e32;
    int e64;
  } exp_t;

  exp_t sb[$];

  leading_zero_cnt #(.WI_SZ(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in(in8),
    .out(out8), .out_q(q8), .zero(z8)
  );
  leading_zero_cnt #(.WI_SZ(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in(in16),
    .out(out16), .out_q(q16), .zero(z16)
  );
  leading_zero_cnt #(.WI_SZ(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in(in32),
    .out(out32), .out_q(q32), .zero(z32)
  );
  leading_zero_cnt #(.WI_SZ(64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in(in64),
    .out(out64), .out_q(q64), .zero(z64)
  );
  leading_zero_cnt #(.WI_SZ(32), .WO_SZ(8)) u_w32w (
    .clk(clk), .rst_n(rst_n), .in(in32),
    .out(out32w), .out_q(q32w), .zero(z32w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan down from the MSB until the first set bit.
  function automatic int ref_lzc(input logic [63:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) return w - 1 - i;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] v);
    in8  = v[7:0];
    in16 = v[15:0];
    in32 = v[31:0];
    in64 = v;
  endtask

  task automatic apply(input logic [63:0] v);
    exp_t e;
    drive(v);
    #1;
    e.e8  = ref_lzc(v, 8);
    e.e16 = ref_lzc(v, 16);
    e.e32 = ref_lzc(v, 32);
    e.e64 = ref_lzc(v, 64);
    chk("out8",   out8,   e.e8);
    chk("out16",  out16,  e.e16);
    chk("out32",  out32,  e.e32);
    chk("out64",  out64,  e.e64);
    chk("out32w", out32w, e.e32);
    chk("zero8",  z8,   v[7:0] == 8'd0);
    chk("zero16", z16,  v[15:0] == 16'd0);
    chk("zero32", z32,  v[31:0] == 32'd0);
    chk("zero64", z64,  v == 64'd0);
    chk("zero32w", z32w, v[31:0] == 32'd0);
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: each rising edge retires the oldest issued vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("q8",   q8,   e.e8);
        chk("q16",  q16,  e.e16);
        chk("q32",  q32,  e.e32);
        chk("q64",  q64,  e.e64);
        chk("q32w", q32w, e.e32);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] one;
    logic [63:0] v;
    rst_n = 1'b0;
    drive(64'd0);
    #2;
    chk("rst_q8",   q8,   0);
    chk("rst_q16",  q16,  0);
    chk("rst_q32",  q32,  0);
    chk("rst_q64",  q64,  0);
    chk("rst_q32w", q32w, 0);
    drive(64'h0000_0000_8000_0000);
    #1;
    chk("rst_out32_tracks", out32, 0);
    chk("rst_zero32_tracks", z32, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero, walking-one and thermometer sweeps for each width.
    for (int wi = 0; wi < 4; wi++) begin
      int w;
      w = 8 << wi;
      @(negedge clk);
      apply(64'd0);
      for (int k = w - 1; k >= 0; k--) begin
        one = 65'd1 << k;
        @(negedge clk);
        apply(one[63:0]);
        one = (65'd1 << (k + 1)) - 65'd1;
        @(negedge clk);
        apply(one[63:0]);
      end
    end

    for (int i = 0; i < 200; i++) begin
      v = {$urandom, $urandom};
      v = v >> $urandom_range(0, 64);
      @(negedge clk);
      apply(v);
    end

    drain();

    // Mid-cycle asynchronous reset with a known 32-bit count of 15.
    @(negedge clk);
    apply(64'h0000_0000_0001_0000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_q8",  q8,  0);
    chk("arst_q16", q16, 0);
    chk("arst_q32", q32, 0);
    chk("arst_q64", q64, 0);
    chk("arst_q32w", q32w, 0);
    chk("arst_out32", out32, 15);
    chk("arst_zero32", z32, 0);
    @(posedge clk);
    #1;
    chk("hold_q32", q32, 0);
    chk("hold_q64", q64, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(64'h0000_0000_0001_0000);

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
